stopwatch_counter_n: RTL and testbench
======================================

// Module: stopwatch_counter_n
// PURPOSE
//  Parametrised min:sec stopwatch core for the lab clock display path. Successor to the
//  two-clock counter: single clock domain with rate strobes instead of derived clocks.
//  Adds up/down count direction, a rollover pulse and a lap-capture register.
//  Feeds the display decoder; button inputs come from the debouncers.
// PARAMETERS
//  MIN_W    6   width of minutes field
//  SEC_W    6   width of seconds field
//  MIN_MAX  59  terminal minutes value (must be < 2**MIN_W)
//  SEC_MAX  59  terminal seconds value (must be < 2**SEC_W)
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset; overrides every other input
//  tick       in   1      1-cycle count strobe (1 Hz in system)
//  tick_adj   in   1      1-cycle adjust strobe (2 Hz in system)
//  adj        in   1      level: 1 = adjust mode
//  sel        in   1      level: adjust target, 1 = seconds, 0 = minutes
//  dir        in   1      level: 0 = count up, 1 = count down
//  pause_btn  in   1      debounced level; each rising edge toggles paused
//  lap_btn    in   1      debounced level; each rising edge captures current time
//  minutes    out  MIN_W  current minutes
//  seconds    out  SEC_W  current seconds
//  paused     out  1      1 = counting halted
//  rollover   out  1      1-cycle pulse when the count wraps
//  lap_min    out  MIN_W  captured minutes
//  lap_sec    out  SEC_W  captured seconds
//  lap_valid  out  1      sticky; set on first capture
// BEHAVIOUR
//  - Reset: minutes=0, seconds=0, paused=0, rollover=0, lap_min=0, lap_sec=0, lap_valid=0,
//    button edge registers=0. Reset asserted mid-count or mid-adjust wins on that edge.
//  - All outputs are registered; a strobe sampled on edge N is visible after edge N.
//  - Edge detect: pause_q/lap_q <= btn; rise = btn & ~q. A held button produces one rise.
//  - Pause: a rise toggles paused. A tick on the same edge uses the old paused value.
//  - Count (adj=0, paused=0, tick=1), dir=0:
//      sec<SEC_MAX -> sec+1; sec==SEC_MAX -> sec=0, min+1;
//      min==MIN_MAX & sec==SEC_MAX -> 0:00 and rollover=1.
//  - Count, dir=1:
//      sec>0 -> sec-1; sec==0 -> sec=SEC_MAX, min-1;
//      0:00 -> MIN_MAX:SEC_MAX and rollover=1.
//  - Adjust (adj=1): tick is ignored. On tick_adj, the field selected by sel increments by 1.
//    The field wraps MAX->0 with no carry into the other field and no rollover pulse.
//    Adjust is always upward, ignores dir, and works whether or not paused.
//    The paused bit itself is unaffected by adjust.
//  - adj=0: tick_adj is ignored. The tick and tick_adj strobes may coincide; only the
//    strobe relevant to the current mode acts.
//  - Lap: a rise loads lap_min/lap_sec with the pre-update minutes/seconds of that edge,
//    even if a tick arrives on the same edge. lap_valid is set to 1 and cleared only by rst.
//  - rollover is 0 on every cycle except a wrapping count edge.
//  - dir, sel and adj may change on any cycle and take effect on the next strobe.
//    No state is lost when they change.
// TESTING
//  1. rst, then 61 ticks with dir=0 -> 01:01, rollover never set.
//  2. Preload 59:59 via adjust, dir=0, one tick -> 00:00 with a 1-cycle rollover pulse.
//  3. From reset, dir=1, one tick -> 59:59 with rollover pulse; next tick -> 59:58.
//  4. pause_btn held for 10 cycles, then 5 ticks -> time unchanged, paused=1.
//     A second press -> paused=0 and counting resumes.
//  5. adj=1, sel=1 at 00:58, 3 tick_adj -> 00:01 (no carry into minutes, no rollover);
//     ticks during this are ignored.
//  6. At 00:07, lap rise and tick on the same edge -> lap=00:07, lap_valid=1, time=00:08.
//     rst mid-count -> all outputs 0.

Source files
------------

// File: rtl/stopwatch_counter_n.sv
// Min:sec stopwatch core on a single clock with rate strobes: up/down count,
// field-wise adjust, pause toggle, rollover pulse and lap capture.
module stopwatch_counter_n #(
    parameter int MIN_W   = 6,
    parameter int SEC_W   = 6,
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             tick_adj,
    input  logic             adj,
    input  logic             sel,
    input  logic             dir,
    input  logic             pause_btn,
    input  logic             lap_btn,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             paused,
    output logic             rollover,
    output logic [MIN_W-1:0] lap_min,
    output logic [SEC_W-1:0] lap_sec,
    output logic             lap_valid
);

    localparam logic [MIN_W-1:0] L_MIN_MAX = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0] L_SEC_MAX = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] L_MIN_ONE = MIN_W'(1);
    localparam logic [SEC_W-1:0] L_SEC_ONE = SEC_W'(1);

    logic [MIN_W-1:0] r_min;
    logic [SEC_W-1:0] r_sec;
    logic             r_paused;
    logic             r_rollover;
    logic [MIN_W-1:0] r_lap_min;
    logic [SEC_W-1:0] r_lap_sec;
    logic             r_lap_valid;
    logic             r_pause_q;
    logic             r_lap_q;

    logic             w_pause_rise;
    logic             w_lap_rise;
    logic [MIN_W-1:0] w_min_nx;
    logic [SEC_W-1:0] w_sec_nx;
    logic             w_roll_nx;

    assign w_pause_rise = pause_btn & ~r_pause_q;
    assign w_lap_rise   = lap_btn & ~r_lap_q;

    always_comb begin
        w_min_nx  = r_min;
        w_sec_nx  = r_sec;
        w_roll_nx = 1'b0;
        if (adj) begin
            // Adjust wraps only the selected field: no carry, no rollover.
            if (tick_adj) begin
                if (sel) begin
                    w_sec_nx = (r_sec == L_SEC_MAX) ? '0 : r_sec + L_SEC_ONE;
                end else begin
                    w_min_nx = (r_min == L_MIN_MAX) ? '0 : r_min + L_MIN_ONE;
                end
            end
        end else if (tick && !r_paused) begin
            if (!dir) begin
                if (r_sec != L_SEC_MAX) begin
                    w_sec_nx = r_sec + L_SEC_ONE;
                end else begin
                    w_sec_nx = '0;
                    if (r_min == L_MIN_MAX) begin
                        w_min_nx  = '0;
                        w_roll_nx = 1'b1;
                    end else begin
                        w_min_nx = r_min + L_MIN_ONE;
                    end
                end
            end else begin
                if (r_sec != '0) begin
                    w_sec_nx = r_sec - L_SEC_ONE;
                end else begin
                    w_sec_nx = L_SEC_MAX;
                    if (r_min == '0) begin
                        w_min_nx  = L_MIN_MAX;
                        w_roll_nx = 1'b1;
                    end else begin
                        w_min_nx = r_min - L_MIN_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min       <= '0;
            r_sec       <= '0;
            r_paused    <= 1'b0;
            r_rollover  <= 1'b0;
            r_lap_min   <= '0;
            r_lap_sec   <= '0;
            r_lap_valid <= 1'b0;
            r_pause_q   <= 1'b0;
            r_lap_q     <= 1'b0;
        end else begin
            r_pause_q  <= pause_btn;
            r_lap_q    <= lap_btn;
            r_min      <= w_min_nx;
            r_sec      <= w_sec_nx;
            r_rollover <= w_roll_nx;
            if (w_pause_rise) begin
                r_paused <= ~r_paused;
            end
            // Lap captures the pre-update time of this edge.
            if (w_lap_rise) begin
                r_lap_min   <= r_min;
                r_lap_sec   <= r_sec;
                r_lap_valid <= 1'b1;
            end
        end
    end

    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign paused    = r_paused;
    assign rollover  = r_rollover;
    assign lap_min   = r_lap_min;
    assign lap_sec   = r_lap_sec;
    assign lap_valid = r_lap_valid;

endmodule

// File: tb/tb_stopwatch_counter_n.sv
// Scenario bench for stopwatch_counter_n: expected states are queued as
// stimulus is applied and popped once the edge has been taken.
module tb_stopwatch_counter_n;

    typedef struct packed {
        logic [5:0] mn;
        logic [5:0] sc;
        logic       p;
        logic       r;
    } st_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       tick_adj = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       dir = 1'b0;
    logic       pause_btn = 1'b0;
    logic       lap_btn = 1'b0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       paused;
    logic       rollover;
    logic [5:0] lap_min;
    logic [5:0] lap_sec;
    logic       lap_valid;

    st_t obs;
    st_t e;
    st_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    assign obs = {minutes, seconds, paused, rollover};

    stopwatch_counter_n #(
        .MIN_W  (6),
        .SEC_W  (6),
        .MIN_MAX(59),
        .SEC_MAX(59)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tick_adj (tick_adj),
        .adj      (adj),
        .sel      (sel),
        .dir      (dir),
        .pause_btn(pause_btn),
        .lap_btn  (lap_btn),
        .minutes  (minutes),
        .seconds  (seconds),
        .paused   (paused),
        .rollover (rollover),
        .lap_min  (lap_min),
        .lap_sec  (lap_sec),
        .lap_valid(lap_valid)
    );

    always #5 clk = ~clk;

    function automatic st_t mk(input int mn, input int sc, input logic p, input logic r);
        st_t s;
        s.mn = 6'(mn);
        s.sc = 6'(sc);
        s.p  = p;
        s.r  = r;
        return s;
    endfunction

    // Inputs are held across the next rising edge, outputs are read 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; tick = 1'b0; tick_adj = 1'b0; adj = 1'b0;
        sel = 1'b0; dir = 1'b0; pause_btn = 1'b0; lap_btn = 1'b0;
    endtask

    task automatic do_rst();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        cyc();
        rst = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                     obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
        end
        n_vec++;
        if ({lap_min, lap_sec, lap_valid} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_lap: got %0d:%0d v=%0b, expected 0:0 v=0",
                     lap_min, lap_sec, lap_valid);
        end
    endtask

    task automatic test_count_up();
        do_rst();
        tick = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            exp_q.push_back(mk(i / 60, i % 60, 1'b0, 1'b0));
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL count_up[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_wrap_up();
        do_rst();
        adj = 1'b1;
        tick_adj = 1'b1;
        for (int i = 1; i <= 118; i++) begin
            sel = (i > 59);
            exp_q.push_back(i <= 59 ? mk(i, 0, 1'b0, 1'b0) : mk(59, i - 59, 1'b0, 1'b0));
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL preload[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        adj = 1'b0; tick_adj = 1'b0; sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick = (i == 0);
            exp_q.push_back(mk(0, 0, 1'b0, i == 0));
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL wrap_up[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_count_down();
        st_t plan[4];
        do_rst();
        plan[0] = mk(59, 59, 1'b0, 1'b1);
        plan[1] = mk(59, 58, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            dir = 1'b1; tick = 1'b1;
            exp_q.push_back(plan[i]);
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL down[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        do_rst();
        // 01:00 via one minute adjust (dir=1 must not affect adjust), then borrow.
        plan[2] = mk(1, 0, 1'b0, 1'b0);
        plan[3] = mk(0, 59, 1'b0, 1'b0);
        for (int i = 2; i < 4; i++) begin
            dir = 1'b1;
            adj = (i == 2); sel = 1'b0; tick_adj = (i == 2); tick = (i == 3);
            exp_q.push_back(plan[i]);
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL down_borrow[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        idle_inputs();
    endtask

    task automatic test_pause();
        do_rst();
        for (int i = 1; i <= 23; i++) begin
            if (i <= 3) begin
                tick = 1'b1; pause_btn = 1'b0;
                exp_q.push_back(mk(0, i, 1'b0, 1'b0));
            end else if (i <= 13) begin
                tick = 1'b0; pause_btn = 1'b1;
                exp_q.push_back(mk(0, 3, 1'b1, 1'b0));
            end else if (i <= 18) begin
                tick = 1'b1; pause_btn = 1'b0;
                exp_q.push_back(mk(0, 3, 1'b1, 1'b0));
            end else if (i == 19) begin
                // Tick on the un-pausing edge still sees the old paused value.
                tick = 1'b1; pause_btn = 1'b1;
                exp_q.push_back(mk(0, 3, 1'b0, 1'b0));
            end else begin
                tick = 1'b1; pause_btn = 1'b0;
                exp_q.push_back(mk(0, i - 16, 1'b0, 1'b0));
            end
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL pause[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        idle_inputs();
    endtask

    task automatic test_adjust();
        do_rst();
        adj = 1'b1; sel = 1'b1; tick_adj = 1'b1;
        repeat (58) cyc();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1, 2: begin adj = 1'b1; tick = 1'b1; tick_adj = 1'b1; end
                3:       begin adj = 1'b1; tick = 1'b1; tick_adj = 1'b0; end
                4:       begin adj = 1'b0; tick = 1'b0; tick_adj = 1'b1; end
                default: begin adj = 1'b0; tick = 1'b1; tick_adj = 1'b1; end
            endcase
            case (i)
                0:       exp_q.push_back(mk(0, 59, 1'b0, 1'b0));
                1:       exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
                2, 3, 4: exp_q.push_back(mk(0, 1, 1'b0, 1'b0));
                default: exp_q.push_back(mk(0, 2, 1'b0, 1'b0));
            endcase
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL adjust[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
        end
        idle_inputs();
    endtask

    task automatic test_lap();
        do_rst();
        tick = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            lap_btn = (i >= 8);
            exp_q.push_back(mk(0, i, 1'b0, 1'b0));
            cyc();
            e = exp_q.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL lap_time[%0d]: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                         i, obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
            end
            if (i >= 8) begin
                n_vec++;
                if ({lap_min, lap_sec, lap_valid} !== {6'd0, 6'd7, 1'b1}) begin
                    n_err++;
                    $display("FAIL lap_capture[%0d]: got %0d:%0d v=%0b, expected 0:7 v=1",
                             i, lap_min, lap_sec, lap_valid);
                end
            end
        end
        lap_btn = 1'b0;
        cyc();
        rst = 1'b1; tick = 1'b1; lap_btn = 1'b1; pause_btn = 1'b1;
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        cyc();
        idle_inputs();
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL rst_mid: got %0d:%0d p=%0b r=%0b, expected %0d:%0d p=%0b r=%0b",
                     obs.mn, obs.sc, obs.p, obs.r, e.mn, e.sc, e.p, e.r);
        end
        n_vec++;
        if ({lap_min, lap_sec, lap_valid} !== 13'd0) begin
            n_err++;
            $display("FAIL rst_mid_lap: got %0d:%0d v=%0b, expected 0:0 v=0",
                     lap_min, lap_sec, lap_valid);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_pause();
        test_adjust();
        test_lap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
